// File: rtl/direction_planner.sv
// Car-direction planner for a single-car elevator serving floors 1..FLOORS.
// Latches hall and car requests into pending registers, which also drive the
// button lamps, and clears them when the car serves them. A collective-selective
// policy picks the next travel direction, stopHere flags a required stop at the
// current floor, and after an idle timeout a park call is raised for HOME_FLOOR.
//
// Handshake: there is no valid/ready pair. Each *Req bit is a level that is
// ORed into its pending register on every clock. enable qualifies the decision,
// clear and park updates. doorState and move qualify when the direction may
// change (door closed and car holding) and when requests may be served (door
// open and car holding).
module direction_planner #(
  parameter int FLOORS       = 7,
  parameter int FLOOR_W      = 3,
  parameter int HOME_FLOOR   = 1,
  parameter int PARK_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [FLOOR_W-1:0] currentFloor,
  input  logic [FLOORS-1:0]  hallUpReq,
  input  logic [FLOORS-1:0]  hallDownReq,
  input  logic [FLOORS-1:0]  carReq,
  input  logic               doorState,
  input  logic               move,
  output logic [1:0]         nextDirection,
  output logic               stopHere,
  output logic [FLOORS-1:0]  pendingUp,
  output logic [FLOORS-1:0]  pendingDown,
  output logic [FLOORS-1:0]  pendingCar
);

  // Direction encoding seen on nextDirection; 2'b11 is never produced.
  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_UP   = 2'b10,
    DIR_DOWN = 2'b01
  } dir_e;

  // The top floor has no up button and the bottom floor has no down button.
  localparam logic [FLOORS-1:0]  UP_MASK   = ~(FLOORS'(1) << (FLOORS - 1));
  localparam logic [FLOORS-1:0]  DOWN_MASK = ~FLOORS'(1);
  localparam logic [FLOORS-1:0]  HOME_MASK = FLOORS'(1) << (HOME_FLOOR - 1);
  localparam logic [FLOOR_W-1:0] TOP_F     = FLOOR_W'(FLOORS);
  localparam logic [FLOOR_W-1:0] HOME_F    = FLOOR_W'(HOME_FLOOR);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   PARK_CNT  = CNT_W'(PARK_TIMEOUT);

  dir_e               dir_q, dir_d;
  dir_e               last_q, last_d;
  logic               stop_q, stop_d;
  logic [FLOORS-1:0]  up_q, up_d;
  logic [FLOORS-1:0]  down_q, down_d;
  logic [FLOORS-1:0]  car_q, car_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               floor_valid;
  logic [FLOOR_W-1:0] floor_m1;
  logic [FLOORS-1:0]  here_mask;
  logic [FLOORS-1:0]  below_mask;
  logic [FLOORS-1:0]  above_mask;
  logic [FLOORS-1:0]  up_now;
  logic [FLOORS-1:0]  down_now;
  logic [FLOORS-1:0]  car_now;
  logic [FLOORS-1:0]  pend_all;
  logic               any_above;
  logic               any_below;
  logic               any_pend;
  logic               here_up;
  logic               here_down;
  logic               here_car;
  logic               fsm_update;
  logic               clear_en;
  logic               idle;
  logic [CNT_W-1:0]   cnt_inc;

  // Floor decode: one-hot position of the car and the masks above/below it.
  always_comb begin
    floor_valid = (currentFloor != '0) && (currentFloor <= TOP_F);
    floor_m1    = currentFloor - FLOOR_W'(1);
    here_mask   = '0;
    below_mask  = '0;
    above_mask  = '0;
    if (floor_valid) begin
      here_mask  = FLOORS'(1) << floor_m1;
      below_mask = here_mask - FLOORS'(1);
      above_mask = ~(here_mask | below_mask);
    end
  end

  // Pending view for this cycle: registered requests merged with new pulses.
  always_comb begin
    up_now    = up_q   | (hallUpReq   & UP_MASK);
    down_now  = down_q | (hallDownReq & DOWN_MASK);
    car_now   = car_q  | carReq;
    pend_all  = up_now | down_now | car_now;
    any_above = |(pend_all & above_mask);
    any_below = |(pend_all & below_mask);
    any_pend  = |pend_all;
    here_up   = |(up_now   & here_mask);
    here_down = |(down_now & here_mask);
    here_car  = |(car_now  & here_mask);
  end

  // Direction FSM: only re-decides while the car holds with its door closed.
  always_comb begin
    dir_d      = dir_q;
    last_d     = last_q;
    fsm_update = enable && !move && !doorState && floor_valid;
    if (fsm_update) begin
      case (dir_q)
        DIR_STOP: begin
          if (any_above && any_below) dir_d = last_q;
          else if (any_above)         dir_d = DIR_UP;
          else if (any_below)         dir_d = DIR_DOWN;
          else                        dir_d = DIR_STOP;
        end
        DIR_UP: begin
          if (any_above)      dir_d = DIR_UP;
          else if (any_below) dir_d = DIR_DOWN;
          else                dir_d = DIR_STOP;
        end
        DIR_DOWN: begin
          if (any_below)      dir_d = DIR_DOWN;
          else if (any_above) dir_d = DIR_UP;
          else                dir_d = DIR_STOP;
        end
        default: dir_d = DIR_STOP;
      endcase
      // Remember the last real travel direction for the STOP tie-break.
      if (dir_d != DIR_STOP) last_d = dir_d;
    end
  end

  // Stop flag: a car call always stops; hall calls depend on travel direction.
  always_comb begin
    stop_d = 1'b0;
    if (floor_valid) begin
      case (dir_q)
        DIR_UP:   stop_d = here_car || here_up   || (here_down && !any_above);
        DIR_DOWN: stop_d = here_car || here_down || (here_up   && !any_below);
        default:  stop_d = here_car || here_up   || here_down;
      endcase
    end
  end

  // Serve requests at an open-door stop, then run the idle/park counter.
  always_comb begin
    up_d     = up_now;
    down_d   = down_now;
    car_d    = car_now;
    cnt_d    = cnt_q;
    clear_en = enable && doorState && !move && floor_valid;
    idle     = enable && (dir_q == DIR_STOP) && !doorState && !move && !any_pend;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // A clear wins over a request arriving for the same bit in the same cycle.
    if (clear_en) begin
      car_d = car_d & ~here_mask;
      if (dir_q != DIR_DOWN) up_d   = up_d   & ~here_mask;
      if (dir_q != DIR_UP)   down_d = down_d & ~here_mask;
    end

    if (enable) begin
      if (idle) begin
        cnt_d = cnt_inc;
        if ((PARK_TIMEOUT != 0) && (cnt_inc >= PARK_CNT) &&
            floor_valid && (currentFloor != HOME_F)) begin
          car_d = car_d | HOME_MASK;
          cnt_d = '0;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // State registers; reset drops every request and parks the FSM in STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q  <= DIR_STOP;
      last_q <= DIR_UP;
      stop_q <= 1'b0;
      up_q   <= '0;
      down_q <= '0;
      car_q  <= '0;
      cnt_q  <= '0;
    end else begin
      dir_q  <= dir_d;
      last_q <= last_d;
      stop_q <= stop_d;
      up_q   <= up_d;
      down_q <= down_d;
      car_q  <= car_d;
      cnt_q  <= cnt_d;
    end
  end

  assign nextDirection = dir_q;
  assign stopHere      = stop_q;
  assign pendingUp     = up_q;
  assign pendingDown   = down_q;
  assign pendingCar    = car_q;

endmodule

// File: tb/tb_direction_planner.sv
// Bench for direction_planner: directed scenarios followed by random traffic,
// every cycle compared against a per-floor behavioural model of the planner.
module tb_direction_planner;

  localparam int FLOORS  = 7;
  localparam int FLOOR_W = 3;
  localparam int HOME    = 1;
  localparam int PT      = 10;
  localparam int CNT_W   = 8;
  localparam int CNT_SAT = 255;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               enable;
  logic [FLOOR_W-1:0] currentFloor;
  logic [FLOORS-1:0]  hallUpReq;
  logic [FLOORS-1:0]  hallDownReq;
  logic [FLOORS-1:0]  carReq;
  logic               doorState;
  logic               move;
  logic [1:0]         nextDirection;
  logic               stopHere;
  logic [FLOORS-1:0]  pendingUp;
  logic [FLOORS-1:0]  pendingDown;
  logic [FLOORS-1:0]  pendingCar;

  direction_planner #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .HOME_FLOOR(HOME),
    .PARK_TIMEOUT(PT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .currentFloor(currentFloor),
    .hallUpReq(hallUpReq), .hallDownReq(hallDownReq), .carReq(carReq),
    .doorState(doorState), .move(move), .nextDirection(nextDirection),
    .stopHere(stopHere), .pendingUp(pendingUp), .pendingDown(pendingDown),
    .pendingCar(pendingCar)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one flag per floor, direction 0=STOP 1=UP 2=DOWN.
  bit m_up  [1:FLOORS];
  bit m_dn  [1:FLOORS];
  bit m_car [1:FLOORS];
  int m_dir;
  int m_last;
  int m_cnt;
  bit m_stop;

  function automatic logic [1:0] dir_bits(input int d);
    case (d)
      1:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit u [1:FLOORS];
    bit d [1:FLOORS];
    bit c [1:FLOORS];
    int f, nd, cnt;
    bit valid, above, below, anyp, hu, hd, hc;
    if (reset) begin
      for (int i = 1; i <= FLOORS; i++) begin
        m_up[i] = 0; m_dn[i] = 0; m_car[i] = 0;
      end
      m_dir = 0; m_last = 1; m_cnt = 0; m_stop = 0;
      return;
    end
    f = int'(currentFloor);
    valid = (f >= 1) && (f <= FLOORS);
    above = 0; below = 0; anyp = 0;
    for (int i = 1; i <= FLOORS; i++) begin
      u[i] = m_up[i]  | (hallUpReq[i-1]   && (i != FLOORS));
      d[i] = m_dn[i]  | (hallDownReq[i-1] && (i != 1));
      c[i] = m_car[i] | carReq[i-1];
      if (u[i] | d[i] | c[i]) begin
        anyp = 1;
        if (i > f) above = 1;
        if (i < f) below = 1;
      end
    end
    hu = 0; hd = 0; hc = 0;
    if (valid) begin
      hu = u[f]; hd = d[f]; hc = c[f];
    end
    // stop flag, judged against the direction held before this edge
    if (!valid)          m_stop = 0;
    else if (m_dir == 1) m_stop = hc || hu || (hd && !above);
    else if (m_dir == 2) m_stop = hc || hd || (hu && !below);
    else                 m_stop = hc || hu || hd;
    // direction decision
    nd = m_dir;
    if (enable && !move && !doorState && valid) begin
      if (m_dir == 0) begin
        if (above && below) nd = m_last;
        else if (above)     nd = 1;
        else if (below)     nd = 2;
        else                nd = 0;
      end else if (m_dir == 1) begin
        nd = above ? 1 : (below ? 2 : 0);
      end else begin
        nd = below ? 2 : (above ? 1 : 0);
      end
    end
    // serving requests at the current floor
    if (enable && doorState && !move && valid) begin
      c[f] = 0;
      if (m_dir != 2) u[f] = 0;
      if (m_dir != 1) d[f] = 0;
    end
    // idle timer and park call
    cnt = m_cnt;
    if (enable) begin
      if (m_dir == 0 && !doorState && !move && !anyp) begin
        cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
        if (PT != 0 && cnt >= PT && valid && f != HOME) begin
          c[HOME] = 1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
    if (nd != 0) m_last = nd;
    m_dir = nd;
    m_cnt = cnt;
    for (int i = 1; i <= FLOORS; i++) begin
      m_up[i] = u[i]; m_dn[i] = d[i]; m_car[i] = c[i];
    end
  endtask

  task automatic compare_all(input string tag);
    logic [FLOORS-1:0] eu, ed, ec;
    for (int i = 1; i <= FLOORS; i++) begin
      eu[i-1] = m_up[i]; ed[i-1] = m_dn[i]; ec[i-1] = m_car[i];
    end
    check({tag, "/dir"},  32'(nextDirection), 32'(dir_bits(m_dir)));
    check({tag, "/stop"}, 32'(stopHere),      32'(m_stop));
    check({tag, "/up"},   32'(pendingUp),     32'(eu));
    check({tag, "/down"}, 32'(pendingDown),   32'(ed));
    check({tag, "/car"},  32'(pendingCar),    32'(ec));
  endtask

  // Driver tasks
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    enable = 1'b1; doorState = 1'b0; move = 1'b0;
    hallUpReq = '0; hallDownReq = '0; carReq = '0;
  endtask

  task automatic do_reset(input int floor);
    reset = 1'b1;
    idle_inputs();
    currentFloor = FLOOR_W'(floor);
    tick("rst");
    tick("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    currentFloor = FLOOR_W'(1);

    // Reset state
    do_reset(1);
    check("reset_dir",  32'(nextDirection), 32'h0);
    check("reset_stop", 32'(stopHere),      32'h0);
    check("reset_pend", 32'({pendingUp, pendingDown, pendingCar}), 32'h0);

    // Simple up call from floor 1 to floor 5
    carReq = 7'b0010000;
    tick("up_call");
    check("up_call_dir", 32'(nextDirection), 32'h2);
    carReq = '0;
    move = 1'b1;
    for (int fl = 2; fl <= 5; fl++) begin
      currentFloor = FLOOR_W'(fl);
      tick("up_travel");
    end
    check("up_arrive_stop", 32'(stopHere), 32'h1);
    move = 1'b0; doorState = 1'b1;
    tick("up_open");
    check("up_open_car", 32'(pendingCar), 32'h0);
    doorState = 1'b0;
    tick("up_close");
    check("up_close_dir", 32'(nextDirection), 32'h0);

    // Reversal: up to 6, then only a down call at floor 2 remains
    do_reset(4);
    hallUpReq = 7'b0100000;
    tick("rev_go");
    hallUpReq = '0;
    move = 1'b1;
    hallDownReq = 7'b0000010;
    tick("rev_dn_pulse");
    hallDownReq = '0;
    currentFloor = FLOOR_W'(5); tick("rev_f5");
    currentFloor = FLOOR_W'(6); tick("rev_f6");
    move = 1'b0; doorState = 1'b1;
    tick("rev_open6");
    check("rev_up_cleared", 32'(pendingUp),   32'h0);
    check("rev_dn_kept",    32'(pendingDown), 32'h2);
    doorState = 1'b0; move = 1'b1;
    currentFloor = FLOOR_W'(5); tick("rev_f5b");
    currentFloor = FLOOR_W'(4); tick("rev_f4");
    move = 1'b0;
    tick("rev_decide");
    check("rev_dir_down", 32'(nextDirection), 32'h1);
    move = 1'b1;
    currentFloor = FLOOR_W'(3); tick("rev_f3");
    currentFloor = FLOOR_W'(2); tick("rev_f2");
    check("rev_stop_f2", 32'(stopHere), 32'h1);
    move = 1'b0; doorState = 1'b1;
    tick("rev_open2");
    check("rev_dn_cleared", 32'(pendingDown), 32'h0);

    // Tie-break after last travelling DOWN
    do_reset(4);
    carReq = 7'b0000010;
    tick("tie_go_down");
    carReq = '0;
    move = 1'b1;
    currentFloor = FLOOR_W'(3); tick("tie_f3");
    currentFloor = FLOOR_W'(2); tick("tie_f2");
    move = 1'b0; doorState = 1'b1;
    tick("tie_open");
    doorState = 1'b0;
    tick("tie_settle");
    check("tie_stopped", 32'(nextDirection), 32'h0);
    move = 1'b1;
    currentFloor = FLOOR_W'(3); tick("tie_f3b");
    currentFloor = FLOOR_W'(4); tick("tie_f4");
    move = 1'b0;
    carReq = 7'b0100010;
    tick("tie_down");
    check("tie_last_down", 32'(nextDirection), 32'h1);
    carReq = '0;

    // Tie-break with lastDir at its reset value UP
    do_reset(4);
    carReq = 7'b0100010;
    tick("tie_up");
    check("tie_last_up", 32'(nextDirection), 32'h2);
    carReq = '0;

    // Parking from floor 5
    do_reset(5);
    for (int i = 0; i < PT - 1; i++) tick("park_wait");
    check("park_not_yet", 32'(pendingCar), 32'h0);
    tick("park_fire");
    check("park_call", 32'(pendingCar), 32'h1);
    tick("park_go");
    check("park_dir", 32'(nextDirection), 32'h1);

    // No park call while already home
    do_reset(1);
    for (int i = 0; i < 300; i++) tick("home_idle");
    check("home_no_park", 32'(pendingCar), 32'h0);

    // Invalid floors and the missing top-up / bottom-down buttons
    do_reset(1);
    carReq = 7'b0010000;
    tick("edge_go");
    carReq = '0;
    currentFloor = FLOOR_W'(0);
    hallUpReq = 7'b1000000; hallDownReq = 7'b0000001;
    tick("edge_f0");
    check("edge_f0_lamps", 32'({pendingUp, pendingDown}), 32'h0);
    check("edge_f0_dir",   32'(nextDirection), 32'h2);
    hallUpReq = '0; hallDownReq = '0; doorState = 1'b1;
    tick("edge_f0_open");
    check("edge_f0_keep", 32'(pendingCar), 32'h10);
    check("edge_f0_stop", 32'(stopHere),   32'h0);
    doorState = 1'b0;
    currentFloor = FLOOR_W'(7);
    hallUpReq = 7'b1000000; hallDownReq = 7'b0000001;
    tick("edge_f7");
    check("edge_f7_lamps", 32'({pendingUp, pendingDown}), 32'h0);
    hallUpReq = '0; hallDownReq = '0;

    // Request and clear of the same bits in one cycle
    do_reset(3);
    doorState = 1'b1;
    carReq = 7'b0000100; hallUpReq = 7'b0000100; hallDownReq = 7'b0000100;
    tick("setclr");
    check("setclr_pend", 32'({pendingUp, pendingDown, pendingCar}), 32'h0);
    idle_inputs();

    // Random traffic against the model
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      enable       = ($urandom_range(0, 7) != 0);
      currentFloor = FLOOR_W'($urandom_range(0, 7));
      doorState    = ($urandom_range(0, 2) == 0);
      move         = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < FLOORS; b++) begin
        hallUpReq[b]   = ($urandom_range(0, 11) == 0);
        hallDownReq[b] = ($urandom_range(0, 11) == 0);
        carReq[b]      = ($urandom_range(0, 11) == 0);
      end
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
